modulation_update_controller: RTL



---
 rtl/modulation_update_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/modulation_update_controller.sv
// Sequences run-time changes of CYCLE_M / FREQ_DIV_M: validate a shadow request, wait for the
// modulation index to wrap, then commit both together. Define MOD_UPDATE_TIMEOUT_EN to force a commit after a WAIT timeout.
module modulation_update_controller #(
    parameter logic [31:0] FREQ_DIV_MIN     = 32'd512,
    parameter logic [15:0] DEFAULT_CYCLE    = 16'd1,
    parameter logic [31:0] DEFAULT_FREQ_DIV = 32'd40960,
    parameter logic [31:0] TIMEOUT_CYCLES   = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        update_req_i,
    input  logic        cancel_i,
    input  logic [15:0] cycle_req_i,
    input  logic [31:0] freq_div_req_i,
    input  logic [15:0] idx_i,
    output logic [15:0] cycle_m_o,
    output logic [31:0] freq_div_m_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] idx_q;
    logic [15:0] shadow_cycle_q, shadow_cycle_d;
    logic [31:0] shadow_div_q, shadow_div_d;
    logic [15:0] cycle_m_q, cycle_m_d;
    logic [31:0] freq_div_m_q, freq_div_m_d;
    logic        err_q, err_d;
    logic        busy_q;
    logic        done_q;
    logic        boundary_s;

    // The index has just wrapped back to zero.
    assign boundary_s = (idx_i == 16'd0) && (idx_q != 16'd0);

`ifdef MOD_UPDATE_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_s;

    assign timeout_s = (wait_cnt_q == (TIMEOUT_CYCLES - 32'd1));
`else
    logic        unused_timeout_s;

    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    // Next-state and next-value logic of the update sequencer.
    always_comb begin
        state_d        = state_q;
        shadow_cycle_d = shadow_cycle_q;
        shadow_div_d   = shadow_div_q;
        cycle_m_d      = cycle_m_q;
        freq_div_m_d   = freq_div_m_q;
        err_d          = err_q;
`ifdef MOD_UPDATE_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (update_req_i) begin
                    shadow_cycle_d = cycle_req_i;
                    shadow_div_d   = freq_div_req_i;
                    state_d        = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (shadow_div_q < FREQ_DIV_MIN) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cycle_m_q == 16'd0) begin
                    // A zero-length period never wraps, so there is nothing to wait for.
                    err_d   = 1'b0;
                    state_d = S_COMMIT;
                end else begin
                    err_d   = 1'b0;
                    state_d = S_WAIT;
`ifdef MOD_UPDATE_TIMEOUT_EN
                    wait_cnt_d = 32'd0;
`endif
                end
            end
            S_WAIT: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else if (boundary_s) begin
                    state_d = S_COMMIT;
`ifdef MOD_UPDATE_TIMEOUT_EN
                end else if (timeout_s) begin
                    state_d = S_COMMIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_COMMIT: begin
                cycle_m_d    = shadow_cycle_q;
                freq_div_m_d = shadow_div_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, shadow, active-parameter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= 16'd0;
            shadow_cycle_q <= DEFAULT_CYCLE;
            shadow_div_q   <= DEFAULT_FREQ_DIV;
            cycle_m_q      <= DEFAULT_CYCLE;
            freq_div_m_q   <= DEFAULT_FREQ_DIV;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_i;
            shadow_cycle_q <= shadow_cycle_d;
            shadow_div_q   <= shadow_div_d;
            cycle_m_q      <= cycle_m_d;
            freq_div_m_q   <= freq_div_m_d;
            err_q          <= err_d;
            busy_q         <= (state_d != S_IDLE);
            done_q         <= (state_d == S_COMMIT);
        end
    end

`ifdef MOD_UPDATE_TIMEOUT_EN
    // WAIT-duration counter used to recover from a stalled sampler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 32'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign cycle_m_o    = cycle_m_q;
    assign freq_div_m_o = freq_div_m_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
